uart_rx_unit: RTL and testbench

UART_RX_UNIT -- requirements
Module: uart_rx_unit

---
 rtl/uart_rx_unit.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_unit
// Brief    : 8-bit UART receiver with 16x oversampling, selectable baud rate,
//            optional odd/even parity, framing/parity error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_unit #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    // Oversample divisors; a result below 1 collapses to one tick per clock.
    localparam int C_DIV_2400  = CLK_FREQ / (16 * 2400);
    localparam int C_DIV_4800  = CLK_FREQ / (16 * 4800);
    localparam int C_DIV_9600  = CLK_FREQ / (16 * 9600);
    localparam int C_DIV_19200 = CLK_FREQ / (16 * 19200);

    localparam logic [31:0] C_LIM_2400  = (C_DIV_2400  > 1) ? 32'(C_DIV_2400  - 1) : 32'd0;
    localparam logic [31:0] C_LIM_4800  = (C_DIV_4800  > 1) ? 32'(C_DIV_4800  - 1) : 32'd0;
    localparam logic [31:0] C_LIM_9600  = (C_DIV_9600  > 1) ? 32'(C_DIV_9600  - 1) : 32'd0;
    localparam logic [31:0] C_LIM_19200 = (C_DIV_19200 > 1) ? 32'(C_DIV_19200 - 1) : 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [1:0]  r_baud;
    logic [1:0]  r_parity;
    logic [31:0] r_div;
    logic [3:0]  r_os;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_perr;

    logic [1:0]  w_baud_sel;
    logic [31:0] w_div_lim;
    logic        w_start;
    logic        w_tick;
    logic        w_sample;
    logic        w_par_en;
    logic        w_par_exp;

    // Live settings in IDLE, frozen copies once a frame has begun.
    assign w_baud_sel = (r_state == ST_IDLE) ? baud_rate : r_baud;
    assign w_start    = (r_state == ST_IDLE) && !r_sync2;
    assign w_tick     = (r_div == w_div_lim);
    assign w_sample   = w_tick && (r_os == 4'd7);
    assign w_par_en   = (r_parity == 2'b01) || (r_parity == 2'b10);
    assign w_par_exp  = (^r_shift) ^ (r_parity == 2'b01);

    // Select the terminal count of the oversample divider.
    always_comb begin
        w_div_lim = C_LIM_9600;
        case (w_baud_sel)
            2'b00:   w_div_lim = C_LIM_2400;
            2'b01:   w_div_lim = C_LIM_4800;
            2'b10:   w_div_lim = C_LIM_9600;
            default: w_div_lim = C_LIM_19200;
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= data_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running oversample divider, realigned to the start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= 32'd0;
        end else if (w_start || w_tick || (r_div > w_div_lim)) begin
            r_div <= 32'd0;
        end else begin
            r_div <= r_div + 32'd1;
        end
    end

    // Frame state machine with registered outputs; samples at tick count 7.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_baud       <= 2'b00;
            r_parity     <= 2'b00;
            r_os         <= 4'd0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            r_perr       <= 1'b0;
            data_out     <= 8'h00;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if ((r_state != ST_IDLE) && w_tick) begin
                r_os <= r_os + 4'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        r_state     <= ST_START;
                        r_os        <= 4'd0;
                        r_bit       <= 3'd0;
                        r_perr      <= 1'b0;
                        r_baud      <= baud_rate;
                        r_parity    <= parity_type;
                        active_flag <= 1'b1;
                        done_flag   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (!r_sync2) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state     <= ST_IDLE;
                            active_flag <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= w_par_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        r_perr  <= (r_sync2 != w_par_exp);
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        data_out     <= r_shift;
                        stop_error   <= ~r_sync2;
                        parity_error <= r_perr;
                        valid        <= 1'b1;
                        done_flag    <= 1'b1;
                        active_flag  <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    active_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_unit
// Brief    : Self-checking bench for uart_rx_unit; expected frames are queued
//            as they are transmitted and checked when valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_unit;

    localparam int CLK_FREQ = 614400;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] baud_rate = 2'b10;
    logic [1:0] parity_type = 2'b00;
    logic       data_rx = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_error;
    logic       stop_error;
    logic       active_flag;
    logic       done_flag;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   valid_cnt = 0;
    int   bit_clks = 64;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock        (clock),
        .reset        (reset),
        .baud_rate    (baud_rate),
        .parity_type  (parity_type),
        .data_rx      (data_rx),
        .data_out     (data_out),
        .valid        (valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    always #5 clock = ~clock;

    // Scoreboard: pop the expected frame whenever valid is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && valid) begin
                valid_cnt++;
                total_cnt++;
                if (prev_valid !== 1'b0) $display("FAIL valid_width: valid high %0d cycles in a row, want single pulse", 2);
                else pass_cnt++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_valid: got valid with data %h, want no frame", data_out);
                end else begin
                    pass_cnt++;
                    e = exp_q.pop_front();
                    total_cnt++;
                    if (data_out !== e.d) $display("FAIL data_out: got %h want %h", data_out, e.d);
                    else pass_cnt++;
                    total_cnt++;
                    if (parity_error !== e.pe) $display("FAIL parity_error: got %b want %b (data %h)", parity_error, e.pe, e.d);
                    else pass_cnt++;
                    total_cnt++;
                    if (stop_error !== e.se) $display("FAIL stop_error: got %b want %b (data %h)", stop_error, e.se, e.d);
                    else pass_cnt++;
                    total_cnt++;
                    if (done_flag !== 1'b1) $display("FAIL done_with_valid: got %b want 1", done_flag);
                    else pass_cnt++;
                end
            end
            prev_valid = reset ? 1'b0 : valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic hold_line(input logic v, input int n);
        data_rx = v;
        repeat (n) @(negedge clock);
    endtask

    // Transmit one frame; settings are scrambled mid-frame to prove they are latched.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt,
                              input logic bad_par, input logic stop_v);
        logic       pbit;
        logic [1:0] b;
        exp_t       e;
        b           = baud_rate;
        parity_type = pt;
        pbit        = (pt == 2'b10) ? (^d) : ~(^d);
        pbit        = pbit ^ bad_par;
        e.d  = d;
        e.pe = ((pt == 2'b01) || (pt == 2'b10)) ? bad_par : 1'b0;
        e.se = ~stop_v;
        exp_q.push_back(e);
        hold_line(1'b0, bit_clks);
        parity_type = pt ^ 2'b11;
        baud_rate   = b ^ 2'b01;
        for (int i = 0; i < 8; i++) hold_line(d[i], bit_clks);
        if ((pt == 2'b01) || (pt == 2'b10)) hold_line(pbit, bit_clks);
        if (stop_v) begin
            hold_line(1'b1, bit_clks);
        end else begin
            hold_line(1'b0, (bit_clks * 5) / 8);
            hold_line(1'b1, bit_clks - (bit_clks * 5) / 8);
        end
        baud_rate   = b;
        parity_type = pt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clock);
        total_cnt++; if (data_out !== 8'h00) $display("FAIL rst_data_out: got %h want 00", data_out); else pass_cnt++;
        total_cnt++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else pass_cnt++;
        total_cnt++; if (parity_error !== 1'b0) $display("FAIL rst_parity_error: got %b want 0", parity_error); else pass_cnt++;
        total_cnt++; if (stop_error !== 1'b0) $display("FAIL rst_stop_error: got %b want 0", stop_error); else pass_cnt++;
        total_cnt++; if (active_flag !== 1'b0) $display("FAIL rst_active: got %b want 0", active_flag); else pass_cnt++;
        total_cnt++; if (done_flag !== 1'b0) $display("FAIL rst_done: got %b want 0", done_flag); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        hold_line(1'b1, 100);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL basic_drain: %0d frames missing, want 0", exp_q.size()); exp_q.delete(); end
        else pass_cnt++;
        total_cnt++; if (active_flag !== 1'b0) $display("FAIL basic_active: got %b want 0", active_flag); else pass_cnt++;
        total_cnt++; if (done_flag !== 1'b1) $display("FAIL basic_done: got %b want 1", done_flag); else pass_cnt++;
    endtask

    task automatic test_parity();
        hold_line(1'b1, 100);
        send_frame(8'h07, 2'b10, 1'b0, 1'b1);
        hold_line(1'b1, 50);
        send_frame(8'h07, 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL parity_drain: %0d frames missing, want 0", exp_q.size()); exp_q.delete(); end
        else pass_cnt++;
        hold_line(1'b1, 30);
        total_cnt++; if (parity_error !== 1'b1) $display("FAIL parity_hold: got %b want 1", parity_error); else pass_cnt++;
    endtask

    task automatic test_stop_error();
        hold_line(1'b1, 100);
        send_frame(8'h3C, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL stop_drain: %0d frames missing, want 0", exp_q.size()); exp_q.delete(); end
        else pass_cnt++;
        hold_line(1'b1, 150);
        total_cnt++; if (stop_error !== 1'b1) $display("FAIL stop_hold: got %b want 1", stop_error); else pass_cnt++;
    endtask

    task automatic test_false_start();
        int vc;
        hold_line(1'b1, 50);
        vc = valid_cnt;
        hold_line(1'b0, 16);
        total_cnt++; if (active_flag !== 1'b1) $display("FAIL fs_active_rise: got %b want 1", active_flag); else pass_cnt++;
        hold_line(1'b1, bit_clks);
        total_cnt++; if (active_flag !== 1'b0) $display("FAIL fs_active_fall: got %b want 0", active_flag); else pass_cnt++;
        total_cnt++; if (valid_cnt !== vc) $display("FAIL fs_no_valid: got %0d pulses want %0d", valid_cnt, vc); else pass_cnt++;
        total_cnt++; if (parity_error !== 1'b0) $display("FAIL fs_parity_keep: got %b want 0", parity_error); else pass_cnt++;
        total_cnt++; if (stop_error !== 1'b1) $display("FAIL fs_stop_keep: got %b want 1", stop_error); else pass_cnt++;
        total_cnt++; if (done_flag !== 1'b0) $display("FAIL fs_done: got %b want 0", done_flag); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int vc;
        hold_line(1'b1, 100);
        vc = valid_cnt;
        send_frame(8'h55, 2'b00, 1'b0, 1'b1);
        send_frame(8'hFF, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL b2b_drain: %0d frames missing, want 0", exp_q.size()); exp_q.delete(); end
        else pass_cnt++;
        total_cnt++; if (valid_cnt !== vc + 2) $display("FAIL b2b_count: got %0d pulses want %0d", valid_cnt - vc, 2); else pass_cnt++;
    endtask

    task automatic test_fast_baud();
        baud_rate = 2'b11;
        bit_clks  = 32;
        hold_line(1'b1, 100);
        send_frame(8'h3A, 2'b10, 1'b0, 1'b1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL baud_drain: %0d frames missing, want 0", exp_q.size()); exp_q.delete(); end
        else pass_cnt++;
        baud_rate = 2'b10;
        bit_clks  = 64;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int         vc;
        d = 8'h6B;
        hold_line(1'b1, 100);
        parity_type = 2'b00;
        hold_line(1'b0, bit_clks);
        for (int i = 0; i < 4; i++) hold_line(d[i], bit_clks);
        hold_line(d[4], bit_clks / 2);
        vc      = valid_cnt;
        reset   = 1'b1;
        data_rx = 1'b1;
        repeat (3) @(negedge clock);
        total_cnt++; if (data_out !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", data_out); else pass_cnt++;
        total_cnt++; if (active_flag !== 1'b0) $display("FAIL mid_rst_active: got %b want 0", active_flag); else pass_cnt++;
        total_cnt++; if (done_flag !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", done_flag); else pass_cnt++;
        total_cnt++; if (valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", valid); else pass_cnt++;
        reset = 1'b0;
        hold_line(1'b1, 12 * bit_clks);
        total_cnt++; if (valid_cnt !== vc) $display("FAIL mid_rst_no_valid: got %0d pulses want %0d", valid_cnt, vc); else pass_cnt++;
        total_cnt++; if (active_flag !== 1'b0) $display("FAIL mid_rst_idle: got %b want 0", active_flag); else pass_cnt++;
        send_frame(8'h81, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL mid_rst_drain: %0d frames missing, want 0", exp_q.size()); exp_q.delete(); end
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_error();
        test_false_start();
        test_back_to_back();
        test_fast_baud();
        test_reset_midframe();
        hold_line(1'b1, 20);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
